// File: rtl/conbus_arb_rr_pkg.sv
// Shared constants and helpers for the conbus round-robin arbiter family.
package conbus_arb_rr_pkg;

    localparam int CONBUS_MAX_MASTERS      = 16;
    localparam int CONBUS_DEFAULT_MAX_HOLD = 16;

    // Reason the owner changes (or not) in the current cycle.
    typedef enum logic [1:0] {
        SW_HOLD    = 2'd0,
        SW_RELEASE = 2'd1,
        SW_TIMEOUT = 2'd2
    } sw_kind_e;

    function automatic int conbus_idx_width(input int n_masters);
        return (n_masters < 2) ? 1 : $clog2(n_masters);
    endfunction

endpackage

// File: rtl/conbus_rr_pick.sv
// Combinational rotate-priority encoder: first set bit of cand at or after start, wrapping.
module conbus_rr_pick
    import conbus_arb_rr_pkg::*;
#(
    parameter int N     = 7,
    parameter int IDX_W = conbus_idx_width(N)
) (
    input  logic [N-1:0]     cand,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    localparam int SW = IDX_W + 1;

    logic [IDX_W-1:0] pos [N];

    // pos[k] = (start + k) mod N, computed by a single conditional subtract since start < N.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pos
            logic [SW-1:0] sum;
            assign sum     = {1'b0, start} + SW'(gi);
            assign pos[gi] = (sum >= SW'(N)) ? IDX_W'(sum - SW'(N)) : IDX_W'(sum);
        end
    endgenerate

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (cand[pos[k]]) begin
                found = 1'b1;
                idx   = pos[k];
            end
        end
    end

endmodule

// File: rtl/conbus_arb_rr.sv
// Round-robin Wishbone bus arbiter with hold timeout, owner lock and parking.
// Optional high-priority candidate filtering is enabled by defining CONBUS_ARB_PRIO_EN.
module conbus_arb_rr
    import conbus_arb_rr_pkg::*;
#(
    parameter int N_MASTERS = 7,
    parameter int MAX_HOLD  = CONBUS_DEFAULT_MAX_HOLD,
    parameter int IDX_W     = conbus_idx_width(N_MASTERS)
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [N_MASTERS-1:0] req,
    input  logic [N_MASTERS-1:0] lock,
`ifdef CONBUS_ARB_PRIO_EN
    input  logic [N_MASTERS-1:0] hi_prio,
`endif
    output logic [N_MASTERS-1:0] gnt,
    output logic [IDX_W-1:0]     gnt_idx,
    output logic                 hold_expired
);

    localparam int  HOLD_W     = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam bit  TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;

    logic [N_MASTERS-1:0] gnt_reg, gnt_next;
    logic [IDX_W-1:0]     gnt_idx_reg, gnt_idx_next;
    logic [HOLD_W-1:0]    hold_cnt_reg, hold_cnt_next;

    logic [IDX_W-1:0]     cur;
    logic [IDX_W-1:0]     start;
    logic [N_MASTERS-1:0] others;
    logic [N_MASTERS-1:0] cand;
    logic                 found;
    logic [IDX_W-1:0]     pick_idx;
    sw_kind_e             sw_kind;

    assign cur    = gnt_idx_reg;
    assign start  = (cur == IDX_W'(N_MASTERS - 1)) ? '0 : cur + 1'b1;
    assign others = req & ~gnt_reg;

`ifdef CONBUS_ARB_PRIO_EN
    logic [N_MASTERS-1:0] hi_cand;
    assign hi_cand = others & hi_prio;
    assign cand    = (|hi_cand) ? hi_cand : others;
`else
    assign cand    = others;
`endif

    conbus_rr_pick #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .cand  (cand),
        .start (start),
        .found (found),
        .idx   (pick_idx)
    );

    // A lock only shields the owner from the timeout; releasing req always hands over.
    always_comb begin
        sw_kind = SW_HOLD;
        if (found) begin
            if (!req[cur]) begin
                sw_kind = SW_RELEASE;
            end else if (TIMEOUT_EN && !lock[cur] && hold_cnt_reg == HOLD_LAST) begin
                sw_kind = SW_TIMEOUT;
            end
        end
    end

    always_comb begin
        gnt_next      = gnt_reg;
        gnt_idx_next  = gnt_idx_reg;
        hold_cnt_next = hold_cnt_reg;
        if (sw_kind != SW_HOLD) begin
            gnt_next     = N_MASTERS'(1) << pick_idx;
            gnt_idx_next = pick_idx;
        end
        if (sw_kind != SW_HOLD || !found || lock[cur] || !TIMEOUT_EN) begin
            hold_cnt_next = '0;
        end else if (req[cur] && hold_cnt_reg != HOLD_LAST) begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            gnt_reg      <= N_MASTERS'(1);
            gnt_idx_reg  <= '0;
            hold_cnt_reg <= '0;
        end else begin
            gnt_reg      <= gnt_next;
            gnt_idx_reg  <= gnt_idx_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    assign gnt          = gnt_reg;
    assign gnt_idx      = gnt_idx_reg;
    assign hold_expired = sys_rst_n && (sw_kind == SW_TIMEOUT);

endmodule

// File: doc/conbus_arb_rr.md
Name: conbus_arb_rr

Overview:
- Parametrised round-robin bus arbiter for the Wishbone interconnect; a successor to the fixed 7-master interconnect arbiter.
- Grants one of N_MASTERS requesters via a one-hot registered grant, parking on the last owner when idle.
- Adds a hold-timeout for forced rotation, a per-master lock that suppresses that timeout, and a binary grant index output.
- Sits between master request lines (cyc) and the interconnect mux/select logic.

Parameters:
- N_MASTERS, 7, number of requesters; legal range 2..16.
- MAX_HOLD, 16, cycles a master may keep the grant while others are waiting; 0 disables the timeout.
- IDX_W, $clog2(N_MASTERS), width of the grant index; derived, never overridden.

Ports:
- sys_clk, in, 1, system clock.
- sys_rst_n, in, 1, synchronous active-low reset.
- req, in, N_MASTERS, per-master bus request (cyc).
- lock, in, N_MASTERS, per-master lock; while asserted by the current owner, the timeout is ignored.
- gnt, out, N_MASTERS, one-hot grant, registered.
- gnt_idx, out, IDX_W, binary index of the granted master, registered, always consistent with gnt.
- hold_expired, out, 1, one-cycle pulse in the cycle a forced rotation is registered.

Behaviour:
- Clocking and reset
  - Single clock domain; all state updates on posedge sys_clk.
  - sys_rst_n=0 sampled at an edge: gnt=1 (master 0), gnt_idx=0, hold counter=0, hold_expired=0.
  - Reset mid-burst drops the grant to master 0 unconditionally.
- Owner state
  - cur = gnt_idx. gnt is exactly one-hot at all times; it never goes to zero, even with no requests (parking).
- Next-owner search
  - Rotate-priority pick starting at (cur+1) mod N_MASTERS and wrapping through cur-1.
  - The current owner is excluded from the candidate set.
- Switch conditions, evaluated each cycle; the new grant appears on the next edge (1-cycle latency):
  - a) req[cur]=0 and any other req set: switch to the pick.
  - b) req[cur]=0 and no other req set: hold cur (park).
  - c) req[cur]=1, lock[cur]=0, MAX_HOLD!=0, hold counter reached MAX_HOLD-1, and any other req set: switch to the pick; hold_expired=1 in that same cycle.
  - d) Otherwise: hold cur.
- Hold counter
  - Width: $clog2(MAX_HOLD+1).
  - Clears on every grant change.
  - Increments while req[cur]=1 and another req is pending; saturates at MAX_HOLD-1.
  - Clears while no other master is requesting.
  - Clears while lock[cur]=1 and stays 0 throughout the locked burst.
- Lock
  - lock[i] is ignored when i != cur.
  - Deasserting req[cur] releases the grant even if lock[cur] is still 1.
- Corner cases
  - Simultaneous release by the owner and request by the owner's neighbour: the neighbour wins.
  - Owner re-asserts req in the same cycle the grant moves away: the owner waits its turn.
  - N_MASTERS that is not a power of 2: the pick never produces an index >= N_MASTERS.

Optional Feature:
- CONBUS_ARB_PRIO_EN, defined:
  - Adds input hi_prio[N_MASTERS-1:0].
  - Candidate set = req & hi_prio & ~owner if non-zero, else req & ~owner. Round-robin order applies within the chosen set.
  - The timeout applies only if a candidate exists in that set.
- CONBUS_ARB_PRIO_EN, undefined:
  - No hi_prio port; plain round robin as above.

Decomposition:
- Shared include conbus_defs.vh:
  - CONBUS_MAX_MASTERS=16.
  - Default MAX_HOLD.
  - Macro for the grant index width.
- Sub-module conbus_rr_pick: combinational rotate-priority encoder.
  - Inputs: candidate vector and start index.
  - Outputs: found flag and index.
  - Reused by future slave-side arbiters.
- Top level holds only the registers, hold counter and switch logic.

Test Plan:
- Reset then idle: req=0 for 10 cycles -> gnt=1, gnt_idx=0, hold_expired=0 throughout.
- N=7, owner 2 releases while req=0b1000011 -> next edge gnt_idx=6; release 6 -> gnt_idx=0; release 0 -> gnt_idx=1 (wrap order).
- MAX_HOLD=4, master 3 holds req, master 5 requests from cycle 0 -> hold_expired pulses in cycle 3, gnt_idx=5 at cycle 4.
- Same as previous with lock[3]=1 for 20 cycles -> no rotation and no pulse; lock drops -> rotation 4 cycles later.
- sys_rst_n=0 for one cycle while gnt_idx=4 -> next edge gnt_idx=0, counter cleared; N=5 random stress checks gnt one-hot and gnt_idx<5.
- CONBUS_ARB_PRIO_EN, owner 0 releases, req=0b0110, hi_prio=0b0100 -> gnt_idx=2 despite master 1 being earlier in rotation.
